cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Splits a WIDTH-bit operation into NUM_STAGES slices. Each slice is built from GROUP-bit lookahead groups.
- The carry between slices is registered at each stage boundary.
- Serves as the next-generation arithmetic block for datapaths that need widths beyond 8 bits at a sustained throughput of one operation per clock.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group_slice.sv | 39 +++
 rtl/cla_pipe_adder.sv | 133 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } cla_ctrl_t;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int group_count(input int width, input int stages, input int group);
        return (width / stages) / group;
    endfunction

endpackage

// File: rtl/cla_group_slice.sv
// Combinational GROUP-bit carry-lookahead cell producing sum, group propagate/generate and carry-out.
module cla_group_slice #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             p_o,
    output logic             g_o,
    output logic             cout_o
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             gg;

    always_comb begin
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c    = '0;
        c[0] = cin_i;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum_o = p ^ c[GROUP-1:0];

        // Group generate is the carry the group would emit with a zero carry-in.
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg = g[i] | (p[i] & gg);
        end
        g_o    = gg;
        p_o    = &p;
        cout_o = gg | (p_o & cin_i);
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/NUM_STAGES slice per stage, valid/ready on both sides.
// Define CLA_PIPE_FLAGS_EN to add registered out_zero / out_ovf result flags.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4,
    parameter int GROUP      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ovf
`endif
);

    localparam int S  = slice_width(WIDTH, NUM_STAGES);
    localparam int NG = group_count(WIDTH, NUM_STAGES, GROUP);

    if ((WIDTH % NUM_STAGES) != 0 || (S % GROUP) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must split into NUM_STAGES slices of whole GROUP-bit groups");
    end

    typedef struct packed {
        cla_ctrl_t        ctrl;
        logic [WIDTH-1:0] sum_partial;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } tok_t;

    // Entry 0 is the accepted operand register; entry NUM_STAGES is the output register.
    tok_t tok_q [NUM_STAGES+1];
    tok_t tok_d [NUM_STAGES+1];

    logic [NUM_STAGES-1:0][S-1:0] slice_sum;
    logic [NUM_STAGES-1:0]        slice_cout;
    logic                         adv;

    assign adv       = ~tok_q[NUM_STAGES].ctrl.valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = tok_q[NUM_STAGES].ctrl.valid;
    assign out_sum   = tok_q[NUM_STAGES].sum_partial;
    assign out_cout  = tok_q[NUM_STAGES].ctrl.carry;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [NG:0]   gc;
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic [NG-1:0] gco;

        assign gc[0] = tok_q[k].ctrl.carry;

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group_slice #(
                .GROUP(GROUP)
            ) u_grp (
                .a_i   (tok_q[k].a_rem[k*S + j*GROUP +: GROUP]),
                .b_i   (tok_q[k].b_rem[k*S + j*GROUP +: GROUP]),
                .cin_i (gc[j]),
                .sum_o (slice_sum[k][j*GROUP +: GROUP]),
                .p_o   (gp[j]),
                .g_o   (gg[j]),
                .cout_o(gco[j])
            );
            assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        assign slice_cout[k] = gco[NG-1];
    end

    always_comb begin
        tok_d[0].ctrl.valid  = in_valid;
        tok_d[0].ctrl.carry  = in_sub | in_cin;
        tok_d[0].sum_partial = '0;
        tok_d[0].a_rem       = in_a;
        tok_d[0].b_rem       = in_b ^ {WIDTH{in_sub}};
        for (int k = 0; k < NUM_STAGES; k++) begin
            tok_d[k+1]                         = tok_q[k];
            tok_d[k+1].sum_partial[k*S +: S]   = slice_sum[k];
            tok_d[k+1].ctrl.carry              = slice_cout[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                tok_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                tok_q[k] <= tok_d[k];
            end
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q,  ovf_d;
    logic msb_cin;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign msb_cin = tok_d[NUM_STAGES].a_rem[WIDTH-1] ^ tok_d[NUM_STAGES].b_rem[WIDTH-1]
                   ^ tok_d[NUM_STAGES].sum_partial[WIDTH-1];
    assign zero_d  = tok_d[NUM_STAGES].ctrl.valid & ~|tok_d[NUM_STAGES].sum_partial;
    assign ovf_d   = tok_d[NUM_STAGES].ctrl.valid & (msb_cin ^ tok_d[NUM_STAGES].ctrl.carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_zero = zero_q;
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed steps in one initial block, scoreboard-checked results.
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         v2, r2, c2, s2, ov2, or2, co2;
    logic [15:0]  a2, b2, sum2;
`ifdef CLA_PIPE_FLAGS_EN
    logic out_zero, out_ovf, z2, f2;
`endif

    cla_pipe_adder #(.WIDTH(W), .NUM_STAGES(N), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef CLA_PIPE_FLAGS_EN
        , .out_zero(out_zero), .out_ovf(out_ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(16), .NUM_STAGES(2), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
        .in_a(a2), .in_b(b2), .in_cin(c2), .in_sub(s2),
        .out_valid(ov2), .out_ready(or2), .out_sum(sum2), .out_cout(co2)
`ifdef CLA_PIPE_FLAGS_EN
        , .out_zero(z2), .out_ovf(f2)
`endif
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_deliv  = 0;
    exp_t sb[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   r;
        exp_t         e;
        be     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.zero = (r[W-1:0] == '0);
        e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", out_sum, e.sum);
                chk("sb_cout", out_cout, e.cout);
`ifdef CLA_PIPE_FLAGS_EN
                chk("sb_zero", out_zero, e.zero);
                chk("sb_ovf", out_ovf, e.ovf);
`endif
                n_deliv++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int   n;
        logic rdy;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        n = 0;
        forever begin
            #2;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(model(a, b, cin, sub));
                break;
            end
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int           lat, d0, seen, n;
        logic [W-1:0] ra [8];
        logic [W-1:0] rb [8];
        logic [16:0]  r16;
        logic [15:0]  be16;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        v2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; s2 = 1'b0; or2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
`ifdef CLA_PIPE_FLAGS_EN
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_ovf", out_ovf, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        chk("latency_basic_add", 64'(lat), 64'(N));

        @(negedge clk);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_out(lat);
        chk("latency_carry_chain", 64'(lat), 64'(N));
        chk("carry_chain_sum", out_sum, 32'h0000_0000);
        chk("carry_chain_cout", out_cout, 1);

        @(negedge clk);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'd7, 32'd5, 1'b0, 1'b1);
        drain();

        @(negedge clk);
        d0 = n_deliv;
        fork
            begin
                for (int i = 0; i < 8; i++) send(ra[i], rb[i], 1'(i), (i % 3) == 0);
            end
            begin : stall_ctl
                logic [W-1:0] held;
                int           k;
                k = 0;
                do begin
                    @(negedge clk);
                    #2;
                    k++;
                end while (!out_valid && k < 50);
                @(negedge clk);
                out_ready = 1'b0;
                #2;
                held = out_sum;
                chk("bp_out_valid", out_valid, 1);
                chk("bp_in_ready", in_ready, 0);
                repeat (2) begin
                    @(negedge clk);
                    #2;
                    chk("bp_in_ready_hold", in_ready, 0);
                    chk("bp_out_sum_hold", out_sum, held);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered_count", 64'(n_deliv - d0), 64'd8);

        @(negedge clk);
        out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        send(32'h5555_5555, 32'h0000_0001, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rf_valid_before_reset", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rf_out_valid_cleared", out_valid, 0);
        chk("rf_out_sum_cleared", out_sum, 0);
        chk("rf_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            #2;
            if (out_valid) seen++;
        end
        chk("rf_no_stale_results", 64'(seen), 64'd0);
        @(negedge clk);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        chk("rf_latency", 64'(lat), 64'(N));
        chk("rf_sum", out_sum, 32'h8000_0000);
        drain();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a2 = 16'($urandom);
            b2 = 16'($urandom);
            c2 = 1'($urandom);
            s2 = (i % 2) == 1;
            if (i == 0) begin
                a2 = 16'hFFFF; b2 = 16'h0000; c2 = 1'b1; s2 = 1'b0;
            end
            chk("w16_in_ready", r2, 1);
            v2 = 1'b1;
            @(negedge clk);
            v2 = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                #2;
                n++;
            end while (!ov2 && n < 20);
            be16 = s2 ? ~b2 : b2;
            r16  = {1'b0, a2} + {1'b0, be16} + {16'd0, (s2 ? 1'b1 : c2)};
            chk("w16_latency", 64'(n), 64'd2);
            chk("w16_sum", sum2, r16[15:0]);
            chk("w16_cout", co2, r16[16]);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
